// File: rtl/ccff_ctrl_pkg.sv
// Shared definitions for the configuration-chain load sequencer.
// FSM encodings, CRC-16-CCITT constants and a single-bit CRC update helper.
package ccff_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // MSB-first update: the incoming bit is folded into the bit leaving the top.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic bit_in);
        crc16_next = {crc[14:0], 1'b0} ^ (((crc[15] ^ bit_in) == 1'b1) ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Serial CRC-16-CCITT over the bits driven onto the configuration chain.
// Only built when CCFF_CRC_EN is defined.
`ifdef CCFF_CRC_EN
module ccff_crc16
    import ccff_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_next(crc, bit_in);
        end
    end

endmodule
`endif

// File: rtl/ccff_load_ctrl.sv
// Configuration-chain load sequencer: streams host words LSB-first onto ccff_head.
// Defining CCFF_CRC_EN adds a CRC-16 check of the shifted stream before I/O release.
module ccff_load_ctrl
    import ccff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              cfg_clk_en,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    input  logic [15:0]       crc_expected,
    output logic              crc_err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BC_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  covered;
    logic [CNT_W-1:0]  remaining;
    logic [WORD_W-1:0] word_buf;
    logic [BC_W-1:0]   buf_cnt;
    logic [BC_W-1:0]   load_cnt;
    logic              can_start;
    logic              enter_load;
    logic              shift_now;
    logic              shift_en;
    logic              accept;
    logic              crc_bad;

    assign can_start  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
    assign enter_load = start && !abort && can_start;
    assign shift_now  = (state == ST_LOAD) && (buf_cnt != '0);
    assign shift_en   = shift_now && !abort;

    // Bits already shifted plus bits waiting in the buffer never exceed the chain length,
    // so "remaining" is the number of chain bits no host word has supplied yet.
    assign covered   = bit_cnt + CNT_W'(buf_cnt);
    assign remaining = LAST_CNT - covered;
    assign load_cnt  = (32'(remaining) < 32'(WORD_W)) ? BC_W'(remaining) : BC_W'(WORD_W);

    assign s_ready = (state == ST_LOAD) && (remaining != '0) && (buf_cnt <= BC_W'(1));
    assign accept  = s_valid && s_ready;

    assign busy      = (state == ST_LOAD) || (state == ST_CHECK);
    assign done      = (state == ST_DONE);
    assign IO_ISOL_N = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start && !abort) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort) state_nxt = ST_IDLE;
                else if (bit_cnt == LAST_CNT) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort) state_nxt = ST_IDLE;
                else if (crc_bad) state_nxt = ST_ERROR;
                else state_nxt = ST_DONE;
            end
            ST_DONE, ST_ERROR: begin
                if (abort) state_nxt = ST_IDLE;
                else if (start) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A word arriving while the last buffered bit leaves overwrites the buffer in the same
    // cycle, which keeps back-to-back words bubble-free.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            bit_cnt    <= '0;
            word_buf   <= '0;
            buf_cnt    <= '0;
            ccff_head  <= 1'b0;
            cfg_clk_en <= 1'b0;
        end else begin
            cfg_clk_en <= shift_en;
            if (shift_en) begin
                ccff_head <= word_buf[0];
            end
            if (enter_load) begin
                bit_cnt <= '0;
            end else if (shift_now) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (enter_load) begin
                word_buf <= '0;
                buf_cnt  <= '0;
            end else if (accept) begin
                word_buf <= s_data;
                buf_cnt  <= load_cnt;
            end else if (shift_now) begin
                word_buf <= word_buf >> 1;
                buf_cnt  <= buf_cnt - BC_W'(1);
            end
        end
    end

`ifdef CCFF_CRC_EN
    logic [15:0] crc;
    logic        unused_tail;

    ccff_crc16 u_crc (
        .clk    (prog_clk),
        .rst    (prog_reset),
        .clr    (enter_load),
        .en     (shift_en),
        .bit_in (word_buf[0]),
        .crc    (crc)
    );

    assign crc_bad     = (crc != crc_expected);
    assign unused_tail = ccff_tail;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            crc_err <= 1'b0;
        end else if (enter_load) begin
            crc_err <= 1'b0;
        end else if ((state == ST_CHECK) && !abort && crc_bad) begin
            crc_err <= 1'b1;
        end
    end
`else
    logic unused_inputs;

    assign crc_bad       = 1'b0;
    assign crc_err       = 1'b0;
    assign unused_inputs = ^{crc_expected, ccff_tail};
`endif

endmodule

// File: tb/tb_ccff_load_ctrl.sv
// Randomized bench for ccff_load_ctrl against a queue-based model of the chain load.
// Build with CCFF_CRC_EN defined to also exercise the CRC pass/fail path.
module tb_ccff_load_ctrl;

    localparam int CL = 10;
    localparam int WW = 4;
`ifdef CCFF_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_CHECK = 2;
    localparam int M_DONE  = 3;
    localparam int M_ERROR = 4;

    logic          prog_clk = 1'b0;
    logic          prog_reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready;
    logic          ccff_head;
    logic          ccff_tail = 1'b0;
    logic          cfg_clk_en;
    logic          IO_ISOL_N;
    logic          busy;
    logic          done;
    logic [15:0]   crc_expected = '0;
    logic          crc_err;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: counts of accepted and shifted bits plus the bit stream itself.
    int          m_state = M_IDLE;
    int          m_acc = 0;
    int          m_sh = 0;
    logic        m_bits[$];
    logic        m_head = 1'b0;
    logic        m_clk_en = 1'b0;
    logic        m_crc_err = 1'b0;
    logic [15:0] m_crc = 16'hFFFF;
    logic        corrupt = 1'b0;

    logic [WW-1:0] host_q[$];
    logic          obs_log[$];
    int            obs_shifts = 0;
    int            obs_hs = 0;

    ccff_load_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .cfg_clk_en   (cfg_clk_en),
        .IO_ISOL_N    (IO_ISOL_N),
        .busy         (busy),
        .done         (done),
        .crc_expected (crc_expected),
        .crc_err      (crc_err)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] crcBit(input logic [15:0] c, input logic b);
        logic [16:0] t;
        t = {c, 1'b0};
        if ((t[16] ^ b) == 1'b1) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0];
    endfunction

    task automatic modelReset();
        m_state = M_IDLE;
        m_acc = 0;
        m_sh = 0;
        m_bits.delete();
        m_head = 1'b0;
        m_clk_en = 1'b0;
        m_crc_err = 1'b0;
        m_crc = 16'hFFFF;
    endtask

    task automatic beginLoad();
        m_state = M_LOAD;
        m_acc = 0;
        m_sh = 0;
        m_bits.delete();
        m_crc = 16'hFFFF;
        m_crc_err = 1'b0;
        corrupt = 1'($urandom_range(1));
    endtask

    // One clock cycle: drive inputs after a falling edge, compare, advance the model.
    task automatic applyStimulus(input logic st, input logic ab, input int vprob);
        int   pending;
        logic exp_ready;
        logic hs;
        logic go_check;
        start = st;
        abort = ab;
        s_valid = (int'($urandom_range(99)) < vprob);
        if (host_q.size() > 0) s_data = host_q[0];
        crc_expected = m_crc ^ {15'd0, corrupt};
        ccff_tail = 1'($urandom_range(1));
        #1;
        pending = m_acc - m_sh;
        exp_ready = (m_state == M_LOAD) && (m_acc < CL) && (pending <= 1);
        checkOutput("s_ready", 32'(s_ready), 32'(exp_ready));
        checkOutput("shift", 32'({cfg_clk_en, ccff_head}), 32'({m_clk_en, m_head}));
        checkOutput("status", 32'({busy, done, IO_ISOL_N, crc_err}),
                    32'({(m_state == M_LOAD) || (m_state == M_CHECK), m_state == M_DONE,
                         m_state == M_DONE, m_crc_err}));
        if (cfg_clk_en) begin
            obs_shifts++;
            obs_log.push_back(ccff_head);
        end
        if (s_valid && s_ready) obs_hs++;
        hs = s_valid && exp_ready;
        case (m_state)
            M_LOAD: begin
                if (ab) begin
                    m_state = M_IDLE;
                    m_clk_en = 1'b0;
                end else begin
                    go_check = (m_sh == CL);
                    if (pending > 0) begin
                        m_head = m_bits[m_sh];
                        m_crc = crcBit(m_crc, m_head);
                        m_sh++;
                        m_clk_en = 1'b1;
                    end else begin
                        m_clk_en = 1'b0;
                    end
                    if (hs) begin
                        for (int i = 0; i < WW; i++) begin
                            if (m_acc < CL) begin
                                m_bits.push_back(s_data[i]);
                                m_acc++;
                            end
                        end
                    end
                    if (go_check) m_state = M_CHECK;
                end
            end
            M_CHECK: begin
                m_clk_en = 1'b0;
                if (ab) m_state = M_IDLE;
                else if (CRC_ON && (crc_expected != m_crc)) begin
                    m_state = M_ERROR;
                    m_crc_err = 1'b1;
                end else m_state = M_DONE;
            end
            M_IDLE: begin
                m_clk_en = 1'b0;
                if (st && !ab) beginLoad();
            end
            default: begin
                m_clk_en = 1'b0;
                if (ab) m_state = M_IDLE;
                else if (st) beginLoad();
            end
        endcase
        if (hs && host_q.size() > 0) void'(host_q.pop_front());
        @(posedge prog_clk);
        @(negedge prog_clk);
        if (hs && host_q.size() == 0) s_data = WW'($urandom);
    endtask

    task automatic runLoad(input int vprob);
        int cyc = 0;
        applyStimulus(1'b1, 1'b0, vprob);
        while (!(m_state == M_DONE || m_state == M_ERROR) && cyc < 80) begin
            applyStimulus(1'b0, 1'b0, vprob);
            cyc++;
        end
        checkOutput("load_complete", 32'(cyc < 80), 32'd1);
    endtask

    task automatic doReset();
        #2;
        prog_reset = 1'b1;
        #1;
        checkOutput("reset_outputs",
                    32'({s_ready, cfg_clk_en, ccff_head, busy, done, IO_ISOL_N, crc_err}), 32'd0);
        modelReset();
        start = 1'b0;
        abort = 1'b0;
        s_valid = 1'b0;
        @(posedge prog_clk);
        @(negedge prog_clk);
        prog_reset = 1'b0;
    endtask

    task automatic checkSequence(input string tag);
        logic [9:0] exp_seq;
        exp_seq = 10'b1101011010;
        checkOutput({tag, "_count"}, 32'(obs_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < obs_log.size()) checkOutput({tag, "_bit"}, 32'(obs_log[i]), 32'(exp_seq[i]));
        end
    endtask

    initial begin
        int cyc;
        int vprob;
        logic st;
        logic ab;
        @(negedge prog_clk);
        @(negedge prog_clk);
        prog_reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 100);

        // Back-to-back words A, 5, 3: ten shifts, upper bits of the last word dropped.
        host_q = '{4'hA, 4'h5, 4'h3};
        obs_shifts = 0;
        obs_hs = 0;
        obs_log.delete();
        runLoad(100);
        checkOutput("b2b_shifts", 32'(obs_shifts), 32'd10);
        checkOutput("b2b_words", 32'(obs_hs), 32'd3);
        checkSequence("b2b_seq");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 100);

        // Host stalls after the first word; the chain just waits.
        host_q = '{4'hA, 4'h5, 4'h3};
        obs_shifts = 0;
        obs_hs = 0;
        obs_log.delete();
        applyStimulus(1'b1, 1'b0, 100);
        cyc = 0;
        while (obs_hs < 1 && cyc < 10) begin
            applyStimulus(1'b0, 1'b0, 100);
            cyc++;
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 0);
        cyc = 0;
        while (m_state != M_DONE && m_state != M_ERROR && cyc < 60) begin
            applyStimulus(1'b0, 1'b0, 100);
            cyc++;
        end
        checkOutput("stall_complete", 32'(cyc < 60), 32'd1);
        checkOutput("stall_shifts", 32'(obs_shifts), 32'd10);
        checkSequence("stall_seq");

        // Abort after five shifts, then a fresh load needs all ten bits again.
        applyStimulus(1'b1, 1'b0, 100);
        cyc = 0;
        while (m_sh < 5 && cyc < 30) begin
            applyStimulus(1'b0, 1'b0, 100);
            cyc++;
        end
        applyStimulus(1'b0, 1'b1, 100);
        checkOutput("abort_idle", 32'({busy, IO_ISOL_N, s_ready, cfg_clk_en}), 32'd0);
        obs_shifts = 0;
        runLoad(100);
        checkOutput("reload_shifts", 32'(obs_shifts), 32'd10);

        // Start during LOAD is ignored; start with abort in DONE goes to IDLE.
        applyStimulus(1'b1, 1'b0, 100);
        applyStimulus(1'b0, 1'b0, 100);
        applyStimulus(1'b1, 1'b0, 100);
        cyc = 0;
        while (m_state != M_DONE && m_state != M_ERROR && cyc < 40) begin
            applyStimulus(1'b0, 1'b0, 100);
            cyc++;
        end
        applyStimulus(1'b1, 1'b1, 100);
        checkOutput("start_abort_idle", 32'({busy, done, IO_ISOL_N}), 32'd0);

        // Random traffic: sporadic start/abort and a varying host duty cycle.
        vprob = 100;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) vprob = int'($urandom_range(100, 20));
            st = (int'($urandom_range(99)) < 4);
            ab = (int'($urandom_range(99)) < 2);
            applyStimulus(st, ab, vprob);
        end

        // Reset in the middle of a load, then recovery.
        applyStimulus(1'b0, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 100);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 100);
        doReset();
        applyStimulus(1'b0, 1'b0, 100);
        obs_shifts = 0;
        runLoad(60);
        checkOutput("post_reset_shifts", 32'(obs_shifts), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
